// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 8;
  localparam int VEC_W  = WORD_W * LANES;
  localparam int CNT_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    VRD,
    VWR,
    RESP
  } state_e;

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous word RAM with registered read-first output.
module sram_sp #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
    dout_q <= mem_q[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage responder: single-cycle scalar accesses, 8-beat serialized
// vector bursts over one word-wide RAM, with busy for pipeline stalling.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LANES = dmem_pkg::LANES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic                     req_vec,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [WORD_W*LANES-1:0]  vwdata,
  output logic [31:0]              rdata,
  output logic [WORD_W*LANES-1:0]  vrdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LANES);
  localparam int VW = WORD_W * LANES;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     base_q, base_d;
  logic [VW-1:0]     vbuf_q, vbuf_d;
  logic [VW-1:0]     vrdata_q, vrdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ld_pend_q, ld_pend_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic [31:0]       last_idx;
  logic              misaligned;
  logic              bad_req;

  assign last_idx   = {2'b00, addr[31:2]} + (req_vec ? 32'(LANES - 1) : 32'd0);
  assign misaligned = req_vec ? (|addr[CW+1:0]) : (|addr[1:0]);
  assign bad_req    = misaligned || (last_idx >= 32'(DEPTH));

  // Vector reads are pipelined one word ahead so the last lane arrives on the final beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    vbuf_d    = vbuf_q;
    vrdata_d  = vrdata_q;
    rdata_d   = rdata_q;
    ld_pend_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr[AW+1:2];
    ram_din   = wdata;

    if (ld_pend_q) begin
      rdata_d = ram_dout;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            if (!req_we) begin
              if (req_vec) begin
                vrdata_d = '0;
              end else begin
                rdata_d = '0;
              end
            end
          end else if (!req_vec) begin
            done_d    = 1'b1;
            ram_we    = req_we;
            ld_pend_d = !req_we;
          end else begin
            base_d  = addr[AW+1:2];
            vbuf_d  = vwdata;
            cnt_d   = '0;
            state_d = req_we ? VWR : VRD;
          end
        end
      end
      VRD: begin
        ram_addr = base_q + AW'(cnt_q) + AW'(1);
        vbuf_d[int'(cnt_q)*WORD_W +: WORD_W] = ram_dout;
        if (cnt_q == CW'(LANES - 1)) begin
          vrdata_d = vbuf_d;
          done_d   = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      VWR: begin
        ram_we   = 1'b1;
        ram_addr = base_q + AW'(cnt_q);
        ram_din  = vbuf_q[int'(cnt_q)*WORD_W +: WORD_W];
        if (cnt_q == CW'(LANES - 1)) begin
          done_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      vbuf_q    <= '0;
      vrdata_q  <= '0;
      rdata_q   <= '0;
      ld_pend_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      vbuf_q    <= vbuf_d;
      vrdata_q  <= vrdata_d;
      rdata_q   <= rdata_d;
      ld_pend_q <= ld_pend_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Reset gates the write so an aborted burst commits no beat at the reset edge.
  sram_sp #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we && !reset),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  assign rdata  = ld_pend_q ? ram_dout : rdata_q;
  assign vrdata = vrdata_q;
  assign busy   = (state_q == VRD) || (state_q == VWR);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed scalar/vector traffic, alignment
// and range errors, and a reset that aborts a vector write mid-burst.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int VW    = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_we;
  logic          req_vec;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [VW-1:0] vwdata;
  logic [31:0]   rdata;
  logic [VW-1:0] vrdata;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(DEPTH), .LANES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_vec   (req_vec),
    .addr      (addr),
    .wdata     (wdata),
    .vwdata    (vwdata),
    .rdata     (rdata),
    .vrdata    (vrdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic          e_err;
    logic          chk_r;
    logic [31:0]   r;
    logic          chk_v;
    logic [VW-1:0] v;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  logic [VW-1:0] vr_model    = '0;

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [31:0] first, input logic [31:0] step);
    logic [VW-1:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = first + step * 32'(i);
    return v;
  endfunction

  task automatic pushExp(input logic e_err, input logic chk_r, input logic [31:0] r,
                         input logic chk_v, input logic [VW-1:0] v);
    exp_t e;
    e.e_err = e_err; e.chk_r = chk_r; e.r = r; e.chk_v = chk_v; e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic we, input logic vec, input logic [31:0] a,
                               input logic [31:0] wd, input logic [VW-1:0] vwd);
    req_valid = 1'b1; req_we = we; req_vec = vec; addr = a; wdata = wd; vwdata = vwd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic scalarOp(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic chk_r, input logic [31:0] e_r);
    pushExp(e_err, chk_r, e_r, 1'b0, '0);
    applyStimulus(we, 1'b0, a, wd, '0);
  endtask

  // Follows a burst to its done pulse; optionally presents a stray store throughout.
  task automatic waitBurst(input bit junk);
    int  busy_cycles = 0;
    bit  seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (junk) begin
        req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b0; addr = 32'h40; wdata = 32'hBAD0BAD0;
      end
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        checkOutput("vrdata_hold_during_burst", vrdata, vr_model);
      end
      if (done) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    checkOutput("burst_done_seen", VW'(seen), VW'(1));
    checkOutput("busy_cycles", VW'(busy_cycles), VW'(8));
    @(posedge clk); #1;
  endtask

  task automatic vectorOp(input logic we, input logic [31:0] a, input logic [VW-1:0] v, input bit junk);
    pushExp(1'b0, 1'b0, '0, !we, v);
    applyStimulus(we, 1'b1, a, '0, v);
    waitBurst(junk);
    if (!we) vr_model = v;
  endtask

  task automatic vectorErr(input logic we, input logic [31:0] a, input logic [VW-1:0] v);
    pushExp(1'b1, 1'b0, '0, !we, '0);
    applyStimulus(we, 1'b1, a, '0, v);
    if (!we) vr_model = '0;
  endtask

  // Scoreboard monitor: every done pulse consumes one expected response.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", VW'(done), VW'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("err_flag", VW'(err), VW'(e.e_err));
        checkOutput("busy_at_done", VW'(busy), VW'(0));
        if (e.chk_r) checkOutput("rdata", VW'(rdata), VW'(e.r));
        if (e.chk_v) checkOutput("vrdata", vrdata, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
    addr = '0; wdata = '0; vwdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_rdata", VW'(rdata), VW'(0));
    checkOutput("reset_vrdata", vrdata, '0);
    checkOutput("reset_busy", VW'(busy), VW'(0));
    checkOutput("reset_done", VW'(done), VW'(0));
    checkOutput("reset_err", VW'(err), VW'(0));

    scalarOp(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("done_after_store", VW'(done), VW'(1));
    scalarOp(1'b0, 32'h10, '0, 1'b0, 1'b1, 32'hDEADBEEF);

    vectorOp(1'b1, 32'h40, mkvec(32'h11111111, 32'h11111111), 1'b0);
    scalarOp(1'b0, 32'h4C, '0, 1'b0, 1'b1, 32'h44444444);

    vectorOp(1'b0, 32'h40, mkvec(32'h11111111, 32'h11111111), 1'b1);
    checkOutput("vrdata_lane0", VW'(vrdata[31:0]), VW'(32'h11111111));
    checkOutput("vrdata_lane7", VW'(vrdata[255:224]), VW'(32'h88888888));
    scalarOp(1'b0, 32'h40, '0, 1'b0, 1'b1, 32'h11111111);

    scalarOp(1'b0, 32'h02, '0, 1'b1, 1'b1, 32'h0);
    scalarOp(1'b1, 32'h12, 32'hFFFFFFFF, 1'b1, 1'b0, '0);
    scalarOp(1'b0, 32'h10, '0, 1'b0, 1'b1, 32'hDEADBEEF);
    vectorErr(1'b1, 32'h44, {8{32'h77777777}});
    scalarOp(1'b0, 32'h44, '0, 1'b0, 1'b1, 32'h22222222);

    scalarOp(1'b1, 32'h0, 32'hCAFE0000, 1'b0, 1'b0, '0);
    scalarOp(1'b1, (DEPTH - 4) * 4, 32'h12345678, 1'b0, 1'b0, '0);
    vectorErr(1'b1, (DEPTH - 4) * 4, {8{32'h55555555}});
    scalarOp(1'b0, 32'h0, '0, 1'b0, 1'b1, 32'hCAFE0000);
    scalarOp(1'b0, (DEPTH - 4) * 4, '0, 1'b0, 1'b1, 32'h12345678);
    vectorErr(1'b0, (DEPTH - 4) * 4, '0);

    vectorOp(1'b1, (DEPTH - 8) * 4, mkvec(32'h01010101, 32'h01010101), 1'b0);
    vectorOp(1'b0, (DEPTH - 8) * 4, mkvec(32'h01010101, 32'h01010101), 1'b0);
    scalarOp(1'b1, DEPTH * 4 - 4, 32'hFEEDFACE, 1'b0, 1'b0, '0);
    scalarOp(1'b0, DEPTH * 4 - 4, '0, 1'b0, 1'b1, 32'hFEEDFACE);
    scalarOp(1'b0, DEPTH * 4, '0, 1'b1, 1'b1, 32'h0);

    // Reset lands on the edge that would commit beat 3 of the second write.
    vectorOp(1'b1, 32'h100, mkvec(32'hA0000000, 32'h1), 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, '0, mkvec(32'hB0000000, 32'h1));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    vr_model = '0;
    @(negedge clk);
    checkOutput("abort_busy", VW'(busy), VW'(0));
    checkOutput("abort_vrdata", vrdata, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", VW'(done), VW'(0));
    end
    for (int i = 0; i < 8; i++) begin
      scalarOp(1'b0, 32'h100 + 32'(4 * i), '0, 1'b0, 1'b1,
               (i < 3) ? 32'hB0000000 + 32'(i) : 32'hA0000000 + 32'(i));
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", VW'(sb_q.size()), VW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
